// File: rtl/m92_pkg.sv
// Shared definitions for the GA21 palette DMA: FSM state encoding and the
// palette RAM word-address width.
package m92_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        WRITE  = 2'd2,
        FINISH = 2'd3
    } dma_state_t;

    localparam int PAL_ADDR_W = 13;

endpackage

// File: rtl/ga21_pal_dma.sv
// Palette DMA initiator: copies a block of 16-bit words from the staging
// buffer into palette RAM, two ce-cycles per word, all outputs registered.
import m92_pkg::*;

module ga21_pal_dma #(
    parameter int ADDR_W = PAL_ADDR_W,
    parameter int SRC_W  = 11,
    parameter int LEN_W  = 13
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ce,
    input  logic              start,
    input  logic              abort,
    input  logic [SRC_W-1:0]  src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [LEN_W-1:0]  length,
    output logic [SRC_W-1:0]  buf_addr,
    input  logic [15:0]       buf_q,
    output logic [ADDR_W-1:0] ga21_addr,
    output logic              ga21_we,
    output logic              ga21_req,
    output logic              dma_busy,
    output logic [15:0]       dout,
    output logic              done,
    output dma_state_t        dbg_state_o
);

    dma_state_t        state_q, state_d;
    logic [SRC_W-1:0]  src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [LEN_W-1:0]  cnt_next;
    logic [SRC_W-1:0]  buf_addr_q, buf_addr_d;
    logic [ADDR_W-1:0] ga21_addr_q, ga21_addr_d;
    logic [15:0]       dout_q, dout_d;
    logic              we_q, we_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    assign cnt_next = cnt_q + LEN_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            buf_addr_q  <= '0;
            ga21_addr_q <= '0;
            dout_q      <= '0;
            we_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            buf_addr_q  <= buf_addr_d;
            ga21_addr_q <= ga21_addr_d;
            dout_q      <= dout_d;
            we_q        <= we_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // The two strobes default low every clk so they last one clk even when
    // ce stays low afterwards; everything else holds unless ce=1.
    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        dst_d       = dst_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        buf_addr_d  = buf_addr_q;
        ga21_addr_d = ga21_addr_q;
        dout_d      = dout_q;
        busy_d      = busy_q;
        we_d        = 1'b0;
        done_d      = 1'b0;
        if (ce) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        src_d  = src_base;
                        dst_d  = dst_base;
                        len_d  = length;
                        cnt_d  = '0;
                        busy_d = 1'b1;
                        if (length == '0) begin
                            state_d = FINISH;
                        end else begin
                            state_d    = READ;
                            buf_addr_d = src_base;
                        end
                    end
                end
                READ: begin
                    if (abort) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = WRITE;
                    end
                end
                WRITE: begin
                    if (abort) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        we_d        = 1'b1;
                        ga21_addr_d = dst_q + ADDR_W'(cnt_q);
                        dout_d      = buf_q;
                        cnt_d       = cnt_next;
                        if (cnt_next == len_q) begin
                            state_d = FINISH;
                        end else begin
                            state_d    = READ;
                            buf_addr_d = src_q + SRC_W'(cnt_next);
                        end
                    end
                end
                FINISH: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    assign buf_addr    = buf_addr_q;
    assign ga21_addr   = ga21_addr_q;
    assign ga21_we     = we_q;
    assign ga21_req    = busy_q;
    assign dma_busy    = busy_q;
    assign dout        = dout_q;
    assign done        = done_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ga21_pal_dma.sv
// Randomized bench for ga21_pal_dma: a staging-buffer RAM model, an expected
// write queue built from the transfer rules, and per-transfer timing checks.
module tb_ga21_pal_dma;

    localparam int ADDR_W = 13;
    localparam int SRC_W  = 11;
    localparam int LEN_W  = 13;

    logic              clk;
    logic              reset_n;
    logic              ce;
    logic              start;
    logic              abort;
    logic [SRC_W-1:0]  src_base;
    logic [ADDR_W-1:0] dst_base;
    logic [LEN_W-1:0]  length;
    logic [SRC_W-1:0]  buf_addr;
    logic [15:0]       buf_q;
    logic [ADDR_W-1:0] ga21_addr;
    logic              ga21_we;
    logic              ga21_req;
    logic              dma_busy;
    logic [15:0]       dout;
    logic              done;
    logic [1:0]        dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] mem [0:2047];
    logic [ADDR_W+15:0] exp_q[$];
    logic prev_we = 1'b0;

    ga21_pal_dma #(.ADDR_W(ADDR_W), .SRC_W(SRC_W), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ce         (ce),
        .start      (start),
        .abort      (abort),
        .src_base   (src_base),
        .dst_base   (dst_base),
        .length     (length),
        .buf_addr   (buf_addr),
        .buf_q      (buf_q),
        .ga21_addr  (ga21_addr),
        .ga21_we    (ga21_we),
        .ga21_req   (ga21_req),
        .dma_busy   (dma_busy),
        .dout       (dout),
        .done       (done),
        .dbg_state_o(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // staging buffer: synchronous read, one ce-cycle latency
    initial buf_q = '0;
    always @(posedge clk) if (ce) buf_q <= mem[buf_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // write scoreboard
    always @(posedge clk) begin
        logic [ADDR_W+15:0] e;
        #1;
        if (reset_n) begin
            if (ga21_we) begin
                check("we_one_clk", prev_we, 1'b0);
                if (exp_q.size() == 0) begin
                    check("unexpected_write", ga21_we, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", ga21_addr, e[ADDR_W+15:16]);
                    check("wr_data", dout, e[15:0]);
                end
            end
            prev_we = ga21_we;
        end else begin
            prev_we = 1'b0;
        end
    end

    // One transfer. abort_at = index of the ce edge (start edge is 1) at which
    // abort is sampled high, or -1. poke drives a stray start mid-transfer.
    task automatic xfer(input int src, input int dst, input int len, input int period,
                        input int abort_at, input bit poke);
        int n, k, guard, busy_n, done_n, lat, nwr, exp_busy;
        bit exp_done;
        logic [ADDR_W-1:0] a;
        exp_done = (abort_at <= 1) || (abort_at >= 2 * len + 2);
        nwr = exp_done ? len : (abort_at - 2) / 2;
        exp_busy = exp_done ? 2 * len + 1 : abort_at - 1;
        for (int i = 0; i < nwr; i++) begin
            a = ADDR_W'(dst + i);
            exp_q.push_back({a, mem[(src + i) % 2048]});
        end
        @(negedge clk);
        src_base = SRC_W'(src);
        dst_base = ADDR_W'(dst);
        length   = LEN_W'(len);
        start    = 1'b1;
        abort    = (abort_at == 1);
        ce       = 1'b1;
        @(posedge clk); #1;
        n = 1; k = 0; guard = 0; done_n = 0; lat = -1;
        busy_n = dma_busy ? 1 : 0;
        while (n < 2 * len + 5 && guard < 2000) begin
            @(negedge clk);
            guard++;
            k++;
            ce    = (k % period == 0);
            start = poke && (n == 3);
            if (start) begin
                src_base = SRC_W'($urandom);
                dst_base = ADDR_W'($urandom);
                length   = LEN_W'($urandom_range(1, 8));
            end
            abort = ce && (n + 1 == abort_at);
            @(posedge clk); #1;
            if (ce) begin
                n++;
                if (dma_busy) busy_n++;
                if (done) begin
                    done_n++;
                    lat = n;
                end
            end
        end
        start = 1'b0;
        abort = 1'b0;
        ce    = 1'b1;
        check("done_cnt", done_n, exp_done);
        if (exp_done) check("latency", lat, 2 * len + 2);
        check("busy_cycles", busy_n, exp_busy);
        check("busy_end", dma_busy, 1'b0);
        check("req_eq_busy", ga21_req, dma_busy);
        check("writes_left", exp_q.size(), 0);
    endtask

    initial begin
        int len, per, ab;
        int done_seen;
        reset_n = 1'b0; ce = 1'b0; start = 1'b0; abort = 1'b0;
        src_base = '0; dst_base = '0; length = '0;
        for (int i = 0; i < 2048; i++) mem[i] = 16'($urandom);
        mem[16'h10] = 16'hAAAA; mem[16'h11] = 16'hBBBB;
        mem[16'h12] = 16'hCCCC; mem[16'h13] = 16'hDDDD;
        #1;
        check("rst_buf_addr", buf_addr, 0);
        check("rst_ga21_addr", ga21_addr, 0);
        check("rst_dout", dout, 0);
        check("rst_we", ga21_we, 0);
        check("rst_req", ga21_req, 0);
        check("rst_busy", dma_busy, 0);
        check("rst_done", done, 0);
        repeat (3) @(posedge clk);
        @(negedge clk); reset_n = 1'b1; ce = 1'b1;
        repeat (2) @(posedge clk);

        xfer(16'h10, 16'h400, 4, 1, -1, 0);    // basic copy
        xfer(5, 7, 0, 1, -1, 0);               // zero length
        xfer(16'h7FF, 16'h1FFE, 3, 1, -1, 0);  // both addresses wrap
        xfer(8190, 8190, 4, 1, -1, 0);
        xfer(16'h20, 16'h100, 2, 3, -1, 0);    // ce one clk in three
        xfer(16'h30, 16'h200, 5, 1, 4, 0);     // abort in READ of word 2
        xfer(16'h40, 16'h300, 1, 1, -1, 0);
        xfer(16'h44, 16'h310, 3, 1, 5, 0);     // abort in WRITE
        xfer(16'h48, 16'h320, 2, 1, 6, 0);     // abort in FINISH ignored
        xfer(16'h4C, 16'h330, 3, 1, 1, 0);     // start beats abort
        xfer(16'h50, 16'h500, 6, 1, -1, 1);    // stray start while busy

        // asynchronous reset during WRITE
        @(negedge clk);
        src_base = 11'h60; dst_base = 13'h600; length = 13'd4; start = 1'b1; ce = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        check("mid_rst_buf_addr", buf_addr, 0);
        check("mid_rst_ga21_addr", ga21_addr, 0);
        check("mid_rst_dout", dout, 0);
        check("mid_rst_we", ga21_we, 0);
        check("mid_rst_req", ga21_req, 0);
        check("mid_rst_busy", dma_busy, 0);
        check("mid_rst_done", done, 0);
        @(negedge clk); reset_n = 1'b1;
        done_seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done || dma_busy) done_seen++;
        end
        check("post_rst_idle", done_seen, 0);
        check("post_rst_writes_left", exp_q.size(), 0);

        for (int t = 0; t < 14; t++) begin
            len = $urandom_range(0, 12);
            per = $urandom_range(1, 3);
            ab  = ($urandom_range(0, 2) == 0) ? $urandom_range(2, 2 * len + 3) : -1;
            xfer($urandom_range(0, 2047), $urandom_range(0, 8191), len, per, ab,
                 (len >= 3) && ($urandom_range(0, 1) == 1));
        end

        repeat (4) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
